// File: rtl/modulo3_reduce_unit.sv
`default_nettype none
// ============================================================================
//  Module   : modulo3_reduce_unit
//  Purpose  : Bit-serial, MSB-first mod-3 reducer for one signed, centered
//             coefficient. Returns the residue of din in R3 over a
//             startmod/moddone handshake.
//  Options  : MOD3_CENTERED_EN - when defined, dout is the centered residue
//             {-1,0,+1} in 2-bit two's complement; otherwise it is {0,1,2}.
//  Revision : 1.0 - initial release
// ============================================================================
module modulo3_reduce_unit #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             startmod,
    input  logic [WIDTH-1:0] din,
    output logic             moddone,
    output logic             busy,
    output logic [1:0]       dout
);

    // Counter must be able to hold WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH + 1);

    // 2^WIDTH mod 3: a negative input read as unsigned is off by 2^WIDTH.
    localparam logic [1:0] c_k = ((WIDTH % 2) == 0) ? 2'd1 : 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIX   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rem;
    logic             r_sign;
    logic [1:0]       r_dout;

    logic [2:0]       w_twice;
    logic [1:0]       w_rem_next;
    logic [2:0]       w_fix_sum;
    logic [1:0]       w_fix_res;
    logic [1:0]       w_result;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs, decoded from state only.
    always_comb begin
        w_state_next = r_state;
        moddone      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (startmod) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                moddone      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Running remainder step: 2r+b is 0..5, one conditional subtract keeps it in 0..2.
    always_comb begin
        w_twice    = {r_rem, r_sh[WIDTH-1]};
        w_rem_next = (w_twice >= 3'd3) ? 2'(w_twice - 3'd3) : w_twice[1:0];
    end

    // Sign correction: subtract 2^WIDTH mod 3 as +(3-k) to stay non-negative.
    always_comb begin
        w_fix_sum = r_sign ? ({1'b0, r_rem} + (3'd3 - {1'b0, c_k})) : {1'b0, r_rem};
        w_fix_res = (w_fix_sum >= 3'd3) ? 2'(w_fix_sum - 3'd3) : w_fix_sum[1:0];
    end

    // Output encoding of the final residue.
    always_comb begin
`ifdef MOD3_CENTERED_EN
        w_result = (w_fix_res == 2'd2) ? 2'b11 : w_fix_res;
`else
        w_result = w_fix_res;
`endif
    end

    // Datapath: load on accept, shift MSB-first, register result at FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_rem  <= 2'd0;
            r_sign <= 1'b0;
            r_dout <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (startmod) begin
                        r_sh   <= din;
                        r_cnt  <= c_cnt_init;
                        r_rem  <= 2'd0;
                        r_sign <= din[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    r_rem <= w_rem_next;
                    r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - c_cnt_last;
                end
                S_FIX: begin
                    r_dout <= w_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire
